// File: rtl/game_hand_engine.sv
// Multi-hand card-total engine: each hand draws until it stands, busts or is forced to stand.
// Optional build macro GAME_SOFT17_HIT_EN: a soft total equal to STAND_AT keeps drawing.
module game_hand_engine #(
    parameter int NUM_HANDS = 2,
    parameter int STAND_AT  = 17,
    parameter int HSEL_W    = 1
) (
    input  logic                     clock,
    input  logic                     new_Game,
    input  logic                     card_valid,
    input  logic [HSEL_W-1:0]        card_hand,
    input  logic [3:0]               card_value,
    output logic                     card_ready,
    input  logic [NUM_HANDS-1:0]     stand_req,
    output logic [NUM_HANDS*6-1:0]   hand_total,
    output logic [NUM_HANDS-1:0]     hand_soft,
    output logic [NUM_HANDS-1:0]     hand_done,
    output logic [NUM_HANDS-1:0]     hand_bust,
    output logic                     all_done,
    output logic                     card_err
);

    typedef enum logic [1:0] {DRAW, STAND, BUST} handState_t;

    localparam logic [6:0] STAND_AT_W = 7'(STAND_AT);
    localparam logic [6:0] LIMIT      = 7'd21;

    handState_t           state      [NUM_HANDS];
    handState_t           nextState  [NUM_HANDS];
    logic [5:0]           total      [NUM_HANDS];
    logic [5:0]           nextTotal  [NUM_HANDS];
    logic [3:0]           softCnt    [NUM_HANDS];
    logic [3:0]           nextSoft   [NUM_HANDS];
    logic [6:0]           sum        [NUM_HANDS];
    logic [3:0]           softAdj    [NUM_HANDS];
    logic [NUM_HANDS-1:0] reachStand;
    logic [NUM_HANDS-1:0] handSel;
    logic [NUM_HANDS-1:0] drawMask;
    logic                 cardLegal;
    logic                 cardTake;

    // Only indices below NUM_HANDS can match, so out-of-range selects are never ready.
    always_comb begin
        handSel  = '0;
        drawMask = '0;
        for (int i = 0; i < NUM_HANDS; i++) begin
            handSel[i]  = (card_hand == HSEL_W'(i));
            drawMask[i] = (state[i] == DRAW);
        end
        card_ready = !new_Game && |(handSel & drawMask);
    end

    assign cardLegal = (card_value >= 4'd2) && (card_value <= 4'd11);
    assign cardTake  = card_valid && card_ready;

    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    always_comb begin
        for (int i = 0; i < NUM_HANDS; i++) begin
            nextState[i]  = state[i];
            nextTotal[i]  = total[i];
            nextSoft[i]   = softCnt[i];
            sum[i]        = {1'b0, total[i]};
            softAdj[i]    = softCnt[i];
            reachStand[i] = 1'b0;
            if (state[i] == DRAW) begin
                if (cardTake && handSel[i] && cardLegal) begin
                    sum[i] = {1'b0, total[i]} + {3'b0, card_value};
                    if (card_value == 4'd11)
                        softAdj[i] = softCnt[i] + 4'd1;
                    // One demotion per card is enough: the pre-card total is at most 20.
                    if (sum[i] > LIMIT && softAdj[i] != 4'd0) begin
                        sum[i]     = sum[i] - 7'd10;
                        softAdj[i] = softAdj[i] - 4'd1;
                    end
                    nextTotal[i] = sum[i][5:0];
                    nextSoft[i]  = softAdj[i];
                end
`ifdef GAME_SOFT17_HIT_EN
                reachStand[i] = (sum[i] >= STAND_AT_W) &&
                                !(sum[i] == STAND_AT_W && softAdj[i] != 4'd0);
`else
                reachStand[i] = (sum[i] >= STAND_AT_W);
`endif
                if (sum[i] > LIMIT)
                    nextState[i] = BUST;
                else if (stand_req[i] || reachStand[i])
                    nextState[i] = STAND;
            end
        end
    end

    // NOTE: the per-hand state arrays are ordinary flops, so every element is reset explicitly.
    always_ff @(posedge clock or posedge new_Game) begin
        if (new_Game) begin
            for (int i = 0; i < NUM_HANDS; i++) begin
                state[i]   <= DRAW;
                total[i]   <= '0;
                softCnt[i] <= '0;
            end
            card_err <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            for (int i = 0; i < NUM_HANDS; i++) begin
                state[i]   <= nextState[i];
                total[i]   <= nextTotal[i];
                softCnt[i] <= nextSoft[i];
            end
            if (cardTake && !cardLegal)
                card_err <= 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_HANDS; i++) begin
            hand_total[6*i +: 6] = total[i];
            hand_soft[i]         = (softCnt[i] != 4'd0);
            hand_done[i]         = (state[i] != DRAW);
            hand_bust[i]         = (state[i] == BUST);
        end
    end

    assign all_done = &hand_done;

endmodule

// File: tb/tb_game_hand_engine.sv
// Self-checking bench for game_hand_engine: directed scenarios plus randomized games
// compared against a card-list model (hard sum with aces as 1, one ace promoted when it fits).
module tb_game_hand_engine;

    localparam int NH = 2;
    localparam int SA = 17;
    localparam int HW = 1;

    logic              clock = 1'b0;
    logic              new_Game;
    logic              card_valid;
    logic [HW-1:0]     card_hand;
    logic [3:0]        card_value;
    logic              card_ready;
    logic [NH-1:0]     stand_req;
    logic [NH*6-1:0]   hand_total;
    logic [NH-1:0]     hand_soft;
    logic [NH-1:0]     hand_done;
    logic [NH-1:0]     hand_bust;
    logic              all_done;
    logic              card_err;

    int checks = 0;
    int errors = 0;

    int mHard  [NH];
    int mAces  [NH];
    bit mStand [NH];
    bit mBust  [NH];
    bit mErr;

    game_hand_engine #(.NUM_HANDS(NH), .STAND_AT(SA), .HSEL_W(HW)) dut (
        .clock      (clock),
        .new_Game   (new_Game),
        .card_valid (card_valid),
        .card_hand  (card_hand),
        .card_value (card_value),
        .card_ready (card_ready),
        .stand_req  (stand_req),
        .hand_total (hand_total),
        .hand_soft  (hand_soft),
        .hand_done  (hand_done),
        .hand_bust  (hand_bust),
        .all_done   (all_done),
        .card_err   (card_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit mSoft(int i);
        return (mAces[i] > 0) && (mHard[i] + 10 <= 21);
    endfunction

    function automatic int mTotal(int i);
        return mSoft(i) ? mHard[i] + 10 : mHard[i];
    endfunction

    function automatic bit mStandsAt(int i);
        int t = mTotal(i);
`ifdef GAME_SOFT17_HIT_EN
        return (t >= SA) && !(t == SA && mSoft(i));
`else
        return t >= SA;
`endif
    endfunction

    function automatic bit mReady(int h);
        return !new_Game && (h < NH) && !mStand[h] && !mBust[h];
    endfunction

    task automatic modelReset();
        for (int i = 0; i < NH; i++) begin
            mHard[i] = 0; mAces[i] = 0; mStand[i] = 0; mBust[i] = 0;
        end
        mErr = 0;
    endtask

    task automatic modelEdge(input bit v, input int h, input int val, input bit [NH-1:0] sr);
        bit accept = v && mReady(h);
        bit legal  = (val >= 2) && (val <= 11);
        if (accept && !legal) mErr = 1;
        for (int i = 0; i < NH; i++) begin
            if (mStand[i] || mBust[i]) continue;
            if (accept && h == i && legal) begin
                mHard[i] += (val == 11) ? 1 : val;
                if (val == 11) mAces[i]++;
            end
            if (mTotal(i) > 21) mBust[i] = 1;
            else if (sr[i] || mStandsAt(i)) mStand[i] = 1;
        end
    endtask

    task automatic checkOutputs(input string tag);
        logic [NH*6-1:0] eTot;
        logic [NH-1:0]   eSoft, eDone, eBust;
        for (int i = 0; i < NH; i++) begin
            eTot[6*i +: 6] = 6'(mTotal(i));
            eSoft[i] = mSoft(i);
            eDone[i] = mStand[i] || mBust[i];
            eBust[i] = mBust[i];
        end
        check({tag, "_total"}, 32'(hand_total), 32'(eTot));
        check({tag, "_soft"},  32'(hand_soft),  32'(eSoft));
        check({tag, "_done"},  32'(hand_done),  32'(eDone));
        check({tag, "_bust"},  32'(hand_bust),  32'(eBust));
        check({tag, "_all"},   32'(all_done),   32'(&eDone));
        check({tag, "_err"},   32'(card_err),   32'(mErr));
    endtask

    // Called at a falling edge; returns at the next falling edge with outputs checked.
    task automatic step(input bit v, input int h, input int val, input bit [NH-1:0] sr,
                        input string tag);
        card_valid = v;
        card_hand  = h[HW-1:0];
        card_value = val[3:0];
        stand_req  = sr;
        #1;
        check({tag, "_ready"}, 32'(card_ready), 32'(mReady(h)));
        @(posedge clock);
        modelEdge(v, h, val, sr);
        @(negedge clock);
        card_valid = 1'b0;
        stand_req  = '0;
        checkOutputs(tag);
    endtask

    task automatic doReset(input string tag);
        new_Game   = 1'b1;
        card_valid = 1'b1;
        card_hand  = '0;
        card_value = 4'd5;
        stand_req  = '1;
        #1;
        modelReset();
        check({tag, "_rst_ready"}, 32'(card_ready), 32'd0);
        checkOutputs({tag, "_rst"});
        @(posedge clock);
        @(negedge clock);
        check({tag, "_rst_ready2"}, 32'(card_ready), 32'd0);
        checkOutputs({tag, "_rst2"});
        new_Game   = 1'b0;
        card_valid = 1'b0;
        stand_req  = '0;
    endtask

    initial begin
        int ill [6] = '{0, 1, 12, 13, 14, 15};
        new_Game = 1'b1; card_valid = 1'b0; card_hand = '0; card_value = '0; stand_req = '0;
        @(negedge clock);

        // Hard 17 stands and blocks further cards.
        doReset("r031");
        step(1, 0, 10, 2'b00, "r031a");
        step(1, 0, 7,  2'b00, "r031b");
        check("r031_tot17", 32'(hand_total[5:0]), 32'd17);
        check("r031_done0", 32'(hand_done[0]), 32'd1);
        step(1, 0, 5, 2'b00, "r031c");
        check("r031_unchanged", 32'(hand_total[5:0]), 32'd17);

        // Soft 17, then a ten (consumed only when soft 17 keeps drawing).
        doReset("r032");
        step(1, 0, 11, 2'b00, "r032a");
        step(1, 0, 6,  2'b00, "r032b");
        check("r032_soft17", 32'(hand_soft[0]), 32'd1);
        step(1, 0, 10, 2'b00, "r032c");
        check("r032_tot17", 32'(hand_total[5:0]), 32'd17);
        check("r032_done", 32'(hand_done[0]), 32'd1);

        // Ace demotion chain on hand1 ending in bust.
        doReset("r033");
        step(1, 1, 11, 2'b00, "r033a");
        check("r033_t11", 32'(hand_total[11:6]), 32'd11);
        step(1, 1, 11, 2'b00, "r033b");
        check("r033_t12s", 32'({hand_total[11:6], hand_soft[1]}), 32'({6'd12, 1'b1}));
        step(1, 1, 10, 2'b00, "r033c");
        check("r033_t12h", 32'({hand_total[11:6], hand_soft[1]}), 32'({6'd12, 1'b0}));
        step(1, 1, 10, 2'b00, "r033d");
        check("r033_t22", 32'(hand_total[11:6]), 32'd22);
        check("r033_bust", 32'(hand_bust[1]), 32'd1);

        // Card and stand request in the same cycle.
        doReset("r034");
        step(1, 0, 9, 2'b01, "r034a");
        check("r034_t9", 32'({hand_total[5:0], hand_done[0]}), 32'({6'd9, 1'b1}));
        step(1, 0, 4, 2'b00, "r034b");
        check("r034_t9b", 32'(hand_total[5:0]), 32'd9);

        // Illegal card sets the sticky error; reset mid-game clears everything.
        doReset("r035");
        step(1, 0, 5,  2'b00, "r035a");
        step(1, 0, 13, 2'b00, "r035b");
        check("r035_err", 32'({card_err, hand_total[5:0]}), 32'({1'b1, 6'd5}));
        step(1, 1, 8, 2'b00, "r035c");
        check("r035_err_sticky", 32'(card_err), 32'd1);
        doReset("r035m");

        // all_done rises on the edge the last hand finishes.
        doReset("r036");
        step(1, 0, 10, 2'b00, "r036a");
        step(1, 1, 10, 2'b00, "r036b");
        step(1, 0, 10, 2'b00, "r036c");
        check("r036_notall", 32'(all_done), 32'd0);
        step(1, 1, 9, 2'b00, "r036d");
        check("r036_all", 32'(all_done), 32'd1);

        // Randomized games against the model, with occasional mid-game resets.
        for (int g = 0; g < 40; g++) begin
            doReset("rg");
            for (int s = 0; s < 25; s++) begin
                bit          v;
                int          h, val;
                bit [NH-1:0] sr;
                v   = ($urandom_range(0, 3) != 0);
                h   = $urandom_range(0, NH - 1);
                val = ($urandom_range(0, 9) == 0) ? ill[$urandom_range(0, 5)]
                                                  : $urandom_range(2, 11);
                for (int i = 0; i < NH; i++) sr[i] = ($urandom_range(0, 11) == 0);
                if ($urandom_range(0, 60) == 0) doReset("rmid");
                step(v, h, val, sr, "rnd");
                if (all_done && $urandom_range(0, 1) == 0) break;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
